// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// fetch_state_t : fetch FSM states
// fetch_entry_t : one queued instruction with the PC it was fetched from
// INSTR_BYTES   : size of one instruction word in bytes
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,   // no request outstanding
        WAIT    = 2'd1,   // request outstanding, its data will be queued
        DISCARD = 2'd2    // request outstanding, its data is stale and dropped
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a single-cycle flush.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
//
// Ports:
//   clk_i, rst_i          clock, async active-low reset (clears storage and pointers)
//   flush_i               drop all entries
//   push_i / push_dat_i   write one entry at the tail
//   pop_i                 retire the head entry
//   head_dat_o            current head entry (meaningful only when !empty_o)
//   count_o, full_o, empty_o  occupancy
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_dat_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch front end: owns the fetch PC, fetches words over req/ack and queues them for decode.
// Latency: ack to inst_valid_o is 1 cycle; zero-wait memory sustains 1 instruction per cycle.
// Backpressure: issue stops when the queue would be full; a redirect flushes the queue.
//
// Ports:
//   clk_i, rst_i                      clock, async active-low reset
//   imem_req_o/addr_o, imem_ack_i/data_i  instruction memory handshake (one request in flight)
//   redirect_i, redirect_pc_i         flush and restart fetch at a new target
//   inst_valid_o, inst_ready_i        decode handshake
//   inst_o, inst_pc_o, inst_pc4_o     head instruction, its PC and PC+4
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_pc4_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    // Address of the stale request kept on the bus while DISCARD waits for its ack;
    // fetch_pc_q already holds the redirect target by then.
    logic [31:0]   disc_addr_q, disc_addr_d;

    logic [31:0]   redirect_tgt;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    fetch_entry_t  push_dat;
    fetch_entry_t  head_dat;

    assign redirect_tgt = redirect_pc_i & ~(32'(INSTR_BYTES) - 32'd1);

    assign imem_req_o  = (state_q == WAIT) || (state_q == DISCARD);
    assign imem_addr_o = (state_q == DISCARD) ? disc_addr_q : fetch_pc_q;

    assign push = (state_q == WAIT) && imem_ack_i && !redirect_i;
    assign pop  = inst_valid_o && inst_ready_i && !redirect_i;

    assign push_dat = '{pc: imem_addr_o, instr: imem_data_i};

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        disc_addr_d = disc_addr_q;
        unique case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_tgt;
                    state_d    = WAIT;
                end else if (!fifo_full || pop) begin
                    // A pop this cycle frees a slot, so the request re-issues
                    // right after it.
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack_i) begin
                    if (redirect_i) begin
                        fetch_pc_d = redirect_tgt;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
                        if (count_nxt >= CW'(DEPTH)) begin
                            state_d = IDLE;
                        end
                    end
                end else if (redirect_i) begin
                    disc_addr_d = fetch_pc_q;
                    fetch_pc_d  = redirect_tgt;
                    state_d     = DISCARD;
                end
            end
            DISCARD: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_tgt;
                end
                if (imem_ack_i) begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            disc_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            disc_addr_q <= disc_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (redirect_i),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .count_o    (count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign inst_valid_o = !fifo_empty;
    assign inst_o       = head_dat.instr;
    assign inst_pc_o    = head_dat.pc;
    assign inst_pc4_o   = head_dat.pc + 32'(INSTR_BYTES);

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: memory model with programmable wait
// states, and a reference that expects decode to see consecutive words starting
// at the last redirect target (or reset PC), each carrying mem_word(pc).
module tb_instr_fetch_buffer;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_pc4_o;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_00C3;
    endfunction

    assign imem_data_i = mem_word(imem_addr_o);

    instr_fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_pc4_o    (inst_pc4_o)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ws = 0;          // memory wait states per request
    int          mem_cnt = 0;     // cycles the current request has been waiting
    int          n_pop = 0;
    int          n_ack = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] last_pop_pc = '0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_i         = 1'b0;
        imem_ack_i    = 1'b0;
        inst_ready_i  = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i     = 1'b1;
        exp_pc    = RESET_PC;
        mem_cnt   = 0;
        ws        = 0;
        n_pop     = 0;
        n_ack     = 0;
        prev_pend = 1'b0;
    endtask

    // One clock: sample outputs, drive inputs for this cycle, update the model, advance.
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic ack;
        if (prev_pend) begin
            chk("req_hold", imem_req_o, 1);
            chk("addr_hold", imem_addr_o, prev_addr);
        end
        chk("addr_align", imem_addr_o[1:0], 0);
        ack = imem_req_o && (mem_cnt >= ws);
        imem_ack_i    = ack;
        inst_ready_i  = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        if (inst_valid_o && rdy && !redir) begin
            chk("pop_pc", inst_pc_o, exp_pc);
            chk("pop_instr", inst_o, mem_word(exp_pc));
            chk("pop_pc4", inst_pc4_o, exp_pc + 32'd4);
            last_pop_pc = inst_pc_o;
            exp_pc      = exp_pc + 32'd4;
            n_pop++;
        end
        if (redir) exp_pc = {rpc[31:2], 2'b00};
        if (ack) n_ack++;
        prev_pend = imem_req_o && !ack;
        prev_addr = imem_addr_o;
        mem_cnt   = ack ? 0 : (imem_req_o ? mem_cnt + 1 : 0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        do_reset();
        chk("rst_req", imem_req_o, 0);
        chk("rst_addr", imem_addr_o, RESET_PC);
        chk("rst_vld", inst_valid_o, 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_pc", inst_pc_o, 0);
        chk("rst_pc4", inst_pc4_o, 4);

        // Zero-wait streaming, decode always ready: one instruction per cycle
        cycle(1, 0, 0);
        chk("first_req", imem_req_o, 1);
        chk("first_addr", imem_addr_o, RESET_PC);
        cycle(1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("stream_vld", inst_valid_o, 1);
            chk("stream_pc", inst_pc_o, 32'(4 * k));
            chk("stream_pc4", inst_pc4_o, 32'(4 * k + 4));
            cycle(1, 0, 0);
        end

        // Decode stalled: exactly DEPTH acks, then requests stop
        do_reset();
        for (int k = 0; k < 12; k++) cycle(0, 0, 0);
        chk("full_acks", n_ack, DEPTH);
        chk("full_req", imem_req_o, 0);
        chk("full_head", inst_pc_o, 0);
        cycle(1, 0, 0);
        chk("reissue_req", imem_req_o, 1);
        chk("reissue_addr", imem_addr_o, 32'd16);
        cycle(0, 0, 0);
        chk("refill_req", imem_req_o, 0);
        chk("refill_acks", n_ack, DEPTH + 1);
        chk("refill_head", inst_pc_o, 32'd4);

        // Redirect during a 3-wait-state request: old data dropped
        do_reset();
        ws = 3;
        cycle(0, 0, 0);
        cycle(0, 1, 32'h40);
        chk("disc_addr", imem_addr_o, 0);
        for (int k = 0; k < 3; k++) cycle(1, 0, 0);
        chk("disc_done_req", imem_req_o, 1);
        chk("disc_done_addr", imem_addr_o, 32'h40);
        chk("disc_done_vld", inst_valid_o, 0);
        for (int k = 0; k < 20 && !inst_valid_o; k++) cycle(0, 0, 0);
        chk("disc_vld", inst_valid_o, 1);
        chk("disc_first_pc", inst_pc_o, 32'h40);

        // Redirect together with ack and pop
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1, 0, 0);
        chk("rdack_pre_vld", inst_valid_o, 1);
        cycle(1, 1, 32'h102);
        chk("rdack_vld", inst_valid_o, 0);
        chk("rdack_req", imem_req_o, 1);
        chk("rdack_addr", imem_addr_o, 32'h100);
        cycle(1, 0, 0);
        chk("rdack_next_pc", inst_pc_o, 32'h100);
        chk("rdack_next_vld", inst_valid_o, 1);

        // Asynchronous reset while WAIT with two entries queued
        do_reset();
        for (int k = 0; k < 3; k++) cycle(0, 0, 0);
        ws = 10;
        chk("mid_pre_req", imem_req_o, 1);
        #3 rst_i = 1'b0;
        #1;
        chk("mid_rst_req", imem_req_o, 0);
        chk("mid_rst_addr", imem_addr_o, RESET_PC);
        chk("mid_rst_vld", inst_valid_o, 0);
        chk("mid_rst_inst", inst_o, 0);
        chk("mid_rst_pc", inst_pc_o, 0);
        chk("mid_rst_pc4", inst_pc4_o, 4);
        do_reset();
        cycle(1, 0, 0);
        chk("restart_addr", imem_addr_o, RESET_PC);
        chk("restart_req", imem_req_o, 1);

        // Wrap-around: 20 pops with random ready and random wait states
        do_reset();
        for (int k = 0; k < 600 && n_pop < 20; k++) begin
            if (mem_cnt == 0) ws = $urandom_range(0, 2);
            cycle(1'($urandom_range(0, 1)), 0, 0);
        end
        chk("wrap_pops", n_pop, 20);
        chk("wrap_last_pc", last_pop_pc, 32'd76);

        // Random traffic with random redirects, including near address wrap
        do_reset();
        for (int k = 0; k < 800; k++) begin
            logic        rd;
            logic [31:0] rp;
            if (mem_cnt == 0) ws = $urandom_range(0, 3);
            rd = ($urandom_range(0, 11) == 0);
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            cycle(1'($urandom_range(0, 2) != 0), rd, rp);
        end
        chk("rand_progress", (n_pop > 40), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
